// File: rtl/ram_bus_pkg.sv
// Shared definitions for the RAM bus arbiter: bus widths, op codes, FSM encoding.
package ram_bus_pkg;

    localparam int ADDR_W  = 23;
    localparam int DATA_W  = 16;
    localparam int NUM_REQ = 3;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    function automatic logic [1:0] oh3_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

endpackage

// File: rtl/ram_bus_arbiter_rr_pick3.sv
// Round-robin pick over three requesters, searching from the one after the last grant.
module rr_pick3 (
    input  logic [2:0] req_valid,
    input  logic [1:0] last_grant,
    output logic [2:0] winner,
    output logic       any_valid
);

    int start;
    int idx;

    always_comb begin
        winner    = 3'b000;
        any_valid = |req_valid;
        start     = (last_grant >= 2'd2) ? 0 : int'(last_grant) + 1;
        idx       = 0;
        for (int k = 0; k < 3; k++) begin
            idx = (start + k) % 3;
            if (winner == 3'b000 && req_valid[idx]) winner[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Three-requester arbiter in front of a single-command RAM controller with
// latch/ready handshake and a per-transaction watchdog.
module ram_bus_arbiter
    import ram_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int NUM_REQ        = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        reqValid,
    input  logic [NUM_REQ-1:0]        reqInstruction,
    input  logic [NUM_REQ*ADDR_W-1:0] reqAddr,
    input  logic [NUM_REQ*DATA_W-1:0] reqData,
    output logic [NUM_REQ-1:0]        reqGrant,
    output logic [NUM_REQ-1:0]        reqDone,
    output logic [DATA_W-1:0]         reqReadData,
    output logic [DATA_W-1:0]         ramBusDataIn,
    output logic [ADDR_W-1:0]         ramBusAddr,
    output logic                      ramInstruction,
    output logic                      ramLatch,
    input  logic                      ramReady,
    input  logic [DATA_W-1:0]         ramBusDataOut,
    output logic                      busy,
    output logic                      timeoutError
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e state_q, state_d;

    logic [1:0]         last_q, last_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               instr_q, instr_d;
    logic               latch_q, latch_d;
    logic               tmo_q, tmo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [2:0]        winner;
    logic              any_valid;
    logic              go;
    logic              tmo_fire;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              win_instr;

    rr_pick3 u_pick (
        .req_valid (reqValid),
        .last_grant(last_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign go = (state_q == ST_IDLE) && ramReady && any_valid;

    // Watchdog only fires while the controller has not yet made the expected move.
    assign tmo_fire = (cnt_q == CNT_LAST) &&
                      (((state_q == ST_WAIT_BUSY) && ramReady) ||
                       ((state_q == ST_WAIT_DONE) && !ramReady));

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (go) state_d = ST_ISSUE;
            ST_ISSUE:     state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (!ramReady || tmo_fire) state_d = tmo_fire ? ST_DONE : ST_WAIT_DONE;
            ST_WAIT_DONE: if (ramReady || tmo_fire) state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        win_addr  = '0;
        win_data  = '0;
        win_instr = OP_READ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                win_addr  = reqAddr[i*ADDR_W +: ADDR_W];
                win_data  = reqData[i*DATA_W +: DATA_W];
                win_instr = reqInstruction[i];
            end
        end

        grant_d = '0;
        done_d  = '0;
        latch_d = 1'b0;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        instr_d = instr_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q | tmo_fire;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    grant_d = NUM_REQ'(winner);
                    last_d  = oh3_to_idx(winner);
                    addr_d  = win_addr;
                    instr_d = win_instr;
                    if (win_instr == OP_WRITE) wdata_d = win_data;
                end
            end
            ST_ISSUE: begin
                latch_d = 1'b1;
                cnt_d   = '0;
            end
            ST_WAIT_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (tmo_fire) rdata_d = '0;
            end
            ST_WAIT_DONE: begin
                cnt_d = cnt_q + 1'b1;
                if (ramReady)      rdata_d = ramBusDataOut;
                else if (tmo_fire) rdata_d = '0;
            end
            ST_DONE: done_d = NUM_REQ'(1) << last_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q  <= 2'd2;
            grant_q <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            instr_q <= OP_READ;
            latch_q <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            last_q  <= last_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            latch_q <= latch_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign reqGrant       = grant_q;
    assign reqDone        = done_q;
    assign reqReadData    = rdata_q;
    assign ramBusDataIn   = wdata_q;
    assign ramBusAddr     = addr_q;
    assign ramInstruction = instr_q;
    assign ramLatch       = latch_q;
    assign busy           = (state_q != ST_IDLE);
    assign timeoutError   = tmo_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants/dones, a negedge monitor pops and checks.
module tb_ram_bus_arbiter;

    localparam int TMO = 20;

    typedef struct {
        int          req;
        bit          wr;
        logic [22:0] addr;
        logic [15:0] data;
        logic [15:0] rd;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  reqValid = '0;
    logic [2:0]  reqInstruction = '0;
    logic [68:0] reqAddr = '0;
    logic [47:0] reqData = '0;
    logic [2:0]  reqGrant, reqDone;
    logic [15:0] reqReadData, ramBusDataIn, ramBusDataOut;
    logic [22:0] ramBusAddr;
    logic        ramInstruction, ramLatch, ramReady, busy, timeoutError;

    logic        ctrl_ready = 1'b1;
    logic        hold_low = 1'b0;
    logic [15:0] ctrl_out = '0;
    int          ctrl_busy = 1;
    logic [15:0] ctrl_rd = '0;

    int total = 0, bad = 0;
    int cyc = 0;
    int grants_seen = 0, dones_seen = 0;
    int grant_cyc = 0;
    bit latch_pending = 0;
    exp_t cur;
    exp_t gq[$];
    exp_t dq[$];

    assign ramReady      = ctrl_ready && !hold_low;
    assign ramBusDataOut = ctrl_out;

    ram_bus_arbiter #(.TIMEOUT_CYCLES(TMO), .NUM_REQ(3)) dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqInstruction(reqInstruction),
        .reqAddr(reqAddr), .reqData(reqData),
        .reqGrant(reqGrant), .reqDone(reqDone), .reqReadData(reqReadData),
        .ramBusDataIn(ramBusDataIn), .ramBusAddr(ramBusAddr),
        .ramInstruction(ramInstruction), .ramLatch(ramLatch),
        .ramReady(ramReady), .ramBusDataOut(ramBusDataOut),
        .busy(busy), .timeoutError(timeoutError)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Controller model: drops ready the cycle after it sees the latch, holds it low ctrl_busy cycles.
    always begin
        @(posedge clk);
        if (ramLatch && !reset) begin
            #1 ctrl_ready = 1'b0;
            repeat (ctrl_busy) @(posedge clk);
            #1;
            ctrl_ready = 1'b1;
            ctrl_out   = ctrl_rd;
        end
    end

    always begin
        exp_t e;
        @(negedge clk);
        if (!reset) begin
            if (reqGrant != 3'b000) begin
                grants_seen++;
                if (gq.size() == 0) chk("grant_unexp", {29'b0, reqGrant}, 32'h0);
                else begin
                    e = gq.pop_front();
                    chk("grant", {29'b0, reqGrant}, 32'(3'b001 << e.req));
                    cur = e;
                    grant_cyc = cyc;
                    latch_pending = 1;
                    dq.push_back(e);
                end
            end
            if (ramLatch) begin
                if (!latch_pending) chk("latch_unexp", {31'b0, ramLatch}, 32'h0);
                else begin
                    chk("latch_cyc", cyc, grant_cyc + 1);
                    chk("latch_addr", {9'b0, ramBusAddr}, {9'b0, cur.addr});
                    chk("latch_instr", {31'b0, ramInstruction}, {31'b0, cur.wr});
                    if (cur.wr) chk("latch_data", {16'b0, ramBusDataIn}, {16'b0, cur.data});
                    chk("busy", {31'b0, busy}, 32'h1);
                    latch_pending = 0;
                end
            end
            if (reqDone != 3'b000) begin
                dones_seen++;
                if (dq.size() == 0) chk("done_unexp", {29'b0, reqDone}, 32'h0);
                else begin
                    e = dq.pop_front();
                    chk("done", {29'b0, reqDone}, 32'(3'b001 << e.req));
                    if (!e.wr) chk("rdata", {16'b0, reqReadData}, {16'b0, e.rd});
                    if (e.lat != 0) chk("latency", cyc - grant_cyc, e.lat);
                end
            end
        end
    end

    task automatic set_req(input int r, input bit wr, input logic [22:0] a, input logic [15:0] d);
        reqInstruction[r]   = wr;
        reqAddr[r*23 +: 23] = a;
        reqData[r*16 +: 16] = d;
    endtask

    task automatic wait_grants(input int target);
        int n = 0;
        while (grants_seen < target && n < 60) begin
            @(negedge clk); #1; n++;
        end
        if (grants_seen < target) chk("grant_wait", grants_seen, target);
    endtask

    task automatic wait_dones(input int target);
        int n = 0;
        while (dones_seen < target && n < 120) begin
            @(negedge clk); #1; n++;
        end
        if (dones_seen < target) chk("done_wait", dones_seen, target);
    endtask

    task automatic txn(input int r, input bit wr, input logic [22:0] a, input logic [15:0] d,
                       input logic [15:0] rd, input int bsy, input int lat);
        exp_t e;
        int g = grants_seen, dn = dones_seen;
        e.req = r; e.wr = wr; e.addr = a; e.data = d; e.rd = rd; e.lat = lat;
        ctrl_busy = bsy; ctrl_rd = rd;
        gq.push_back(e);
        set_req(r, wr, a, d);
        reqValid[r] = 1'b1;
        wait_grants(g + 1);
        reqValid[r] = 1'b0;
        wait_dones(dn + 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_grant"}, {29'b0, reqGrant}, 0);
        chk({tag, "_done"}, {29'b0, reqDone}, 0);
        chk({tag, "_rdata"}, {16'b0, reqReadData}, 0);
        chk({tag, "_latch_instr_busy"}, {29'b0, ramLatch, ramInstruction, busy}, 0);
        chk({tag, "_addr"}, {9'b0, ramBusAddr}, 0);
        chk({tag, "_wdata"}, {16'b0, ramBusDataIn}, 0);
        chk({tag, "_tmo"}, {31'b0, timeoutError}, 0);
    endtask

    initial begin
        exp_t e;
        int g, dn;

        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        txn(0, 1'b1, 23'h000010, 16'hBEEF, 16'h0000, 2, 6);
        txn(1, 1'b0, 23'h000222, 16'h5555, 16'h1234, 1, 5);
        chk("wdata_kept_on_read", {16'b0, ramBusDataIn}, 32'hBEEF);
        txn(2, 1'b1, 23'h7FFFFF, 16'h0F0F, 16'h0000, 3, 7);

        // All three requesting for six arbitrations
        g = grants_seen; dn = dones_seen;
        ctrl_busy = 1;
        for (int k = 0; k < 6; k++) begin
            e.req = k % 3; e.wr = 1'b1; e.addr = 23'h100 + 23'(k % 3);
            e.data = 16'hA000 + 16'(k % 3); e.rd = 16'h0; e.lat = 5;
            gq.push_back(e);
        end
        for (int r = 0; r < 3; r++) set_req(r, 1'b1, 23'h100 + 23'(r), 16'hA000 + 16'(r));
        reqValid = 3'b111;
        wait_grants(g + 6);
        reqValid = 3'b000;
        wait_dones(dn + 6);

        // Controller not ready: requests must stall
        g = grants_seen;
        hold_low = 1'b1;
        for (int r = 0; r < 3; r++) set_req(r, 1'b1, 23'h200 + 23'(r), 16'hC000 + 16'(r));
        reqValid = 3'b111;
        repeat (10) @(negedge clk);
        chk("stall_no_grant", grants_seen, g);
        e.req = 0; e.wr = 1'b1; e.addr = 23'h200; e.data = 16'hC000; e.rd = 0; e.lat = 5;
        gq.push_back(e);
        dn = dones_seen;
        hold_low = 1'b0;
        @(negedge clk);
        chk("grant_after_ready", {29'b0, reqGrant}, 32'h1);
        #1 reqValid = 3'b000;
        wait_dones(dn + 1);

        // Controller hangs past the watchdog
        txn(1, 1'b0, 23'h000333, 16'h0, 16'h0000, 30, TMO + 2);
        chk("tmo_set", {31'b0, timeoutError}, 32'h1);
        repeat (15) @(negedge clk);
        txn(2, 1'b1, 23'h000444, 16'h4444, 16'h0, 1, 5);
        chk("tmo_sticky", {31'b0, timeoutError}, 32'h1);

        // Reset in WAIT_DONE abandons the read
        g = grants_seen;
        ctrl_busy = 8;
        e.req = 1; e.wr = 1'b0; e.addr = 23'h000555; e.data = 0; e.rd = 16'h9999; e.lat = 0;
        ctrl_rd = 16'h9999;
        gq.push_back(e);
        set_req(1, 1'b0, 23'h000555, 16'h0);
        reqValid[1] = 1'b1;
        wait_grants(g + 1);
        reqValid[1] = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        gq.delete(); dq.delete(); latch_pending = 0;
        @(negedge clk);
        check_reset_vals("midrst");
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("no_done_after_rst", {29'b0, reqDone}, 0);

        g = grants_seen; dn = dones_seen;
        ctrl_busy = 1;
        e.req = 0; e.wr = 1'b1; e.addr = 23'h000600; e.data = 16'h6000; e.rd = 0; e.lat = 5;
        gq.push_back(e);
        for (int r = 0; r < 3; r++) set_req(r, 1'b1, 23'h600 + 23'(r), 16'h6000 + 16'(r));
        reqValid = 3'b111;
        wait_grants(g + 1);
        reqValid = 3'b000;
        wait_dones(dn + 1);

        repeat (3) @(negedge clk);
        chk("gq_left", gq.size(), 0);
        chk("dq_left", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ram_bus_arbiter.md
RAM_BUS_ARBITER -- requirements
Module: ram_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023: maximum cycles allowed in WAIT_BUSY plus WAIT_DONE per transaction.
REQ-002 Parameter NUM_REQ, default 3: requester count, fixed at 3.
- 0: DNA initializer.
- 1: network evaluator.
- 2: GA writer.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 reqValid  in  3  per-requester request; bit i = requester i.
REQ-006 reqInstruction  in  3  per-requester op; 0=READ, 1=WRITE.
REQ-007 reqAddr  in  69  packed word addresses; requester i at bits [23*i+22 : 23*i], mapping to RAM address [23:1].
REQ-008 reqData  in  48  packed write data; requester i at bits [16*i+15 : 16*i].
REQ-009 reqGrant  out  3  one-hot, one-cycle pulse when requester i's fields are captured.
REQ-010 reqDone  out  3  one-hot, one-cycle pulse when requester i's transaction completes.
REQ-011 reqReadData  out  16  read data; valid in the cycle reqDone is high for a READ.
REQ-012 ramBusDataIn  out  16  write data to RAM controller.
REQ-013 ramBusAddr  out  23  RAM word address [23:1].
REQ-014 ramInstruction  out  1  0=READ, 1=WRITE.
REQ-015 ramLatch  out  1  one-cycle command strobe.
REQ-016 ramReady  in  1  high = controller idle/complete.
REQ-017 ramBusDataOut  in  16  controller read data; valid when ramReady returns high.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 timeoutError  out  1  sticky flag; cleared only by reset.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE and DONE.
REQ-021 IDLE SHALL grant only when ramReady=1 and reqValid!=0.
- Winner is picked round-robin, searching from (lastGrant+1) mod 3.
- In that cycle: capture the winner's addr/data/instruction into the ram* output registers, pulse reqGrant[winner], update lastGrant, go to ISSUE.
REQ-022 ISSUE SHALL drive ramLatch=1 for exactly one cycle, then go to WAIT_BUSY.
- ramLatch is fully synchronous: no negedge logic and no multi-cycle strobe.
REQ-023 WAIT_BUSY SHALL wait for ramReady=0, then go to WAIT_DONE.
REQ-024 WAIT_DONE SHALL wait for ramReady=1, then go to DONE.
- On that same edge, capture ramBusDataOut into reqReadData.
REQ-025 DONE SHALL pulse reqDone[lastGrant] for one cycle, then go to IDLE.
REQ-026 Minimum request-to-done latency SHALL be 5 cycles from the grant edge.
- Sequence: grant, latch, busy seen, ready seen, done.
REQ-027 ram* address, data and instruction outputs SHALL hold stable from ISSUE through DONE.
REQ-028 reqValid SHALL be sampled only in IDLE.
- A requester deasserting in the arbitration cycle is not granted.
- A requester holding reqValid after its done pulse re-arbitrates normally.
REQ-029 A requester SHALL hold its fields stable until its reqGrant; the arbiter does not re-sample them after grant.
REQ-030 With ramReady=0 in IDLE, no grant SHALL occur, regardless of reqValid.
REQ-031 A cycle counter SHALL clear on entry to WAIT_BUSY.
- On reaching TIMEOUT_CYCLES in WAIT_BUSY or WAIT_DONE: set timeoutError, go to DONE, pulse reqDone.
- On timeout, reqReadData = 16'h0000.
REQ-032 READ transactions SHALL leave ramBusDataIn unchanged.
REQ-033 reqReadData SHALL be undefined for WRITE transactions.
REQ-034 Round-robin SHALL give any continuously requesting requester a grant within 3 arbitrations.

Reset
REQ-035 While reset=1, the block SHALL hold these values:
- state=IDLE, lastGrant=2 (requester 0 wins first).
- reqGrant=0, reqDone=0, reqReadData=0.
- ramLatch=0, ramInstruction=READ, ramBusAddr=0, ramBusDataIn=0.
- busy=0, timeoutError=0, counter=0.
REQ-036 Reset asserted mid-transaction SHALL abandon it: no reqDone, and ramLatch=0 on the next edge.

Structure
REQ-037 Shared package ram_bus_pkg SHALL hold:
- READ/WRITE constants.
- ADDR_W=23, DATA_W=16, NUM_REQ=3.
- FSM state encoding.
REQ-038 Combinational round-robin pick SHALL be sub-module rr_pick3.
- Inputs: reqValid, lastGrant.
- Outputs: one-hot winner, anyValid.

Verification
REQ-039 After reset, a single WRITE from requester 0 (addr 23'h000010, data 16'hBEEF) with a controller busy 2 cycles SHALL produce:
- reqGrant=001.
- ramLatch high 1 cycle, with ramBusAddr=23'h000010, ramBusDataIn=BEEF, ramInstruction=1.
- reqDone=001 exactly 6 cycles after grant.
REQ-040 READ from requester 1 with controller returning 16'h1234 SHALL give reqDone=010 with reqReadData=1234 in the same cycle.
REQ-041 All three reqValid held high for 6 transactions SHALL give grant order 0,1,2,0,1,2.
REQ-042 ramReady held low after ISSUE for TIMEOUT_CYCLES SHALL give:
- timeoutError=1 and reqDone pulse with reqReadData=0.
- timeoutError stays 1 through later normal transactions until reset.
REQ-043 Reset asserted in WAIT_DONE SHALL give: no reqDone, all outputs at reset values next cycle, next grant to requester 0.
REQ-044 reqValid=111 with ramReady=0 in IDLE for 10 cycles SHALL give no grant and no latch; the grant follows 1 cycle after ramReady rises.
